// File: rtl/jogo_sequencia_uc_param_if.sv
// Signal bundle between the sequence-game control unit and its datapath/panel.
// The master side is the control unit; the slave side is everything it drives.
interface jogo_sequencia_uc_param_if #(
    parameter int N_JOGADAS = 16,
    parameter int VIDAS     = 1
);
    localparam int AW = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1;
    localparam int VW = $clog2(VIDAS + 1);

    logic          iniciar;
    logic          modo;
    logic          jogada;
    logic          igual;
    logic [AW-1:0] endereco;
    logic [AW-1:0] rodada;
    logic [VW-1:0] vidas;
    logic          registraR;
    logic          limpaR;
    logic          penalidade;
    logic          pronto;
    logic          ganhou;
    logic          perdeu;
    logic          timeout;
    logic [3:0]    db_estado;

    modport master (
        input  iniciar, modo, jogada, igual,
        output endereco, rodada, vidas, registraR, limpaR, penalidade,
               pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        output iniciar, modo, jogada, igual,
        input  endereco, rodada, vidas, registraR, limpaR, penalidade,
               pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_uc_param.sv
// Control unit for the sequence-memory game: sequences rounds and plays and owns
// the round, address, per-play timeout and lives counters.
module jogo_sequencia_uc_param #(
    parameter int N_JOGADAS      = 16,
    parameter int N_CURTO        = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int VIDAS          = 1
) (
    input  logic clock,
    input  logic reset,
    jogo_sequencia_uc_param_if.master bus
);
    localparam int AW = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1;
    localparam int VW = $clog2(VIDAS + 1);
    localparam int TW = $clog2(TIMEOUT_CICLOS);

    localparam logic [3:0] INICIAL         = 4'h0;
    localparam logic [3:0] PREPARACAO      = 4'h1;
    localparam logic [3:0] INICIA_RODADA   = 4'h2;
    localparam logic [3:0] ESPERA_JOGADA   = 4'h3;
    localparam logic [3:0] REGISTRA_JOGADA = 4'h4;
    localparam logic [3:0] COMPARA_JOGADA  = 4'h5;
    localparam logic [3:0] PROXIMA_JOGADA  = 4'h6;
    localparam logic [3:0] ULTIMA_RODADA   = 4'h7;
    localparam logic [3:0] PROXIMA_RODADA  = 4'h8;
    localparam logic [3:0] FINAL_ERROU     = 4'h9;
    localparam logic [3:0] FINAL_ACERTOU   = 4'hA;
    localparam logic [3:0] FINAL_TIMEOUT   = 4'hB;
    localparam logic [3:0] ST_PENALIDADE   = 4'hC;

    localparam logic [AW-1:0] ULTIMA_CURTO = AW'(N_CURTO - 1);
    localparam logic [AW-1:0] ULTIMA_LONGO = AW'(N_JOGADAS - 1);
    localparam logic [TW-1:0] TIMER_MAX    = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [VW-1:0] VIDAS_INI    = VW'(VIDAS);

    logic [3:0]    estado;
    logic [3:0]    proximo;
    logic [AW-1:0] endereco;
    logic [AW-1:0] rodada;
    logic [AW-1:0] ultima;      // limite-1, so it always fits in AW bits
    logic [VW-1:0] vidas;
    logic [TW-1:0] timer;
    logic          jogada_d;
    logic          borda;
    logic          tem_vida;
    logic          estourou;

    assign borda    = bus.jogada & ~jogada_d;
    assign tem_vida = vidas > VW'(1);
    assign estourou = timer == TIMER_MAX;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= INICIAL;
            jogada_d <= 1'b0;
        end else begin
            estado   <= proximo;
            jogada_d <= bus.jogada;
        end
    end

    // NOTE: proximo gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring a latch.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:         proximo = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:      proximo = INICIA_RODADA;
            INICIA_RODADA:   proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (borda)
                    proximo = REGISTRA_JOGADA;
                else if (estourou)
                    proximo = tem_vida ? ST_PENALIDADE : FINAL_TIMEOUT;
                else
                    proximo = ESPERA_JOGADA;
            end
            REGISTRA_JOGADA: proximo = COMPARA_JOGADA;
            COMPARA_JOGADA: begin
                if (!bus.igual)
                    proximo = tem_vida ? ST_PENALIDADE : FINAL_ERROU;
                else if (endereco == rodada)
                    proximo = ULTIMA_RODADA;
                else
                    proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:  proximo = ESPERA_JOGADA;
            ULTIMA_RODADA:   proximo = (rodada == ultima) ? FINAL_ACERTOU : PROXIMA_RODADA;
            PROXIMA_RODADA:  proximo = INICIA_RODADA;
            ST_PENALIDADE:   proximo = INICIA_RODADA;
            FINAL_ERROU, FINAL_ACERTOU, FINAL_TIMEOUT:
                             proximo = bus.iniciar ? PREPARACAO : estado;
            default:         proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco <= '0;
            rodada   <= '0;
            vidas    <= '0;
            timer    <= '0;
            ultima   <= ULTIMA_CURTO;
        end else begin
            case (estado)
                PREPARACAO: begin
                    endereco <= '0;
                    rodada   <= '0;
                    vidas    <= VIDAS_INI;
                    timer    <= '0;
                    ultima   <= bus.modo ? ULTIMA_LONGO : ULTIMA_CURTO;
                end
                INICIA_RODADA: begin
                    endereco <= '0;
                    timer    <= '0;
                end
                ESPERA_JOGADA:  timer <= timer + TW'(1);
                PROXIMA_JOGADA: begin
                    endereco <= endereco + AW'(1);
                    timer    <= '0;
                end
                PROXIMA_RODADA: rodada <= rodada + AW'(1);
                ST_PENALIDADE:  vidas  <= vidas - VW'(1);
                default: ;
            endcase
        end
    end

    // Moore outputs; an out-of-range state code is flagged as F for debug.
    assign bus.endereco   = endereco;
    assign bus.rodada     = rodada;
    assign bus.vidas      = vidas;
    assign bus.registraR  = estado == REGISTRA_JOGADA;
    assign bus.limpaR     = (estado == INICIAL) || (estado == PREPARACAO);
    assign bus.penalidade = estado == ST_PENALIDADE;
    assign bus.pronto     = (estado == FINAL_ERROU) || (estado == FINAL_ACERTOU) ||
                            (estado == FINAL_TIMEOUT);
    assign bus.ganhou     = estado == FINAL_ACERTOU;
    assign bus.perdeu     = (estado == FINAL_ERROU) || (estado == FINAL_TIMEOUT);
    assign bus.timeout    = estado == FINAL_TIMEOUT;
    assign bus.db_estado  = (estado > ST_PENALIDADE) ? 4'hF : estado;
endmodule

// File: tb/tb_jogo_sequencia_uc_param.sv
// Bench for jogo_sequencia_uc_param: directed game scenarios plus random play,
// all checked every cycle against a game-level reference model.
module tb_jogo_sequencia_uc_param;
    localparam int NJ = 4;
    localparam int NC = 2;
    localparam int TO = 10;
    localparam int NV = 2;

    // Observable state codes of the game.
    localparam int C_INICIAL = 0, C_PREP = 1, C_RODADA = 2, C_ESPERA = 3, C_REGISTRA = 4;
    localparam int C_COMPARA = 5, C_PROX_JOG = 6, C_ULTIMA = 7, C_PROX_ROD = 8;
    localparam int C_ERROU = 9, C_ACERTOU = 10, C_TIMEOUT = 11, C_PENAL = 12;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    jogo_sequencia_uc_param_if #(.N_JOGADAS(NJ), .VIDAS(NV)) bus ();

    jogo_sequencia_uc_param #(
        .N_JOGADAS(NJ), .N_CURTO(NC), .TIMEOUT_CICLOS(TO), .VIDAS(NV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game-level model: where the game is, address/round/lives, and how many
    // cycles the current wait for a press has lasted.
    int   m_st, m_end, m_rod, m_vid, m_wait, m_lim;
    logic m_jd;

    always @(posedge clock or posedge reset) begin : model
        int st, en, ro, vi, wa, li;
        logic press;
        if (reset) begin
            m_st <= C_INICIAL; m_end <= 0; m_rod <= 0; m_vid <= 0;
            m_wait <= 0; m_lim <= NC; m_jd <= 1'b0;
        end else begin
            st = m_st; en = m_end; ro = m_rod; vi = m_vid; wa = m_wait; li = m_lim;
            press = bus.jogada && !m_jd;
            case (st)
                C_INICIAL:  if (bus.iniciar) st = C_PREP;
                C_PREP:     begin ro = 0; en = 0; vi = NV; li = bus.modo ? NJ : NC; st = C_RODADA; end
                C_RODADA:   begin en = 0; wa = 0; st = C_ESPERA; end
                C_ESPERA: begin
                    wa = wa + 1;
                    if (press) st = C_REGISTRA;
                    else if (wa == TO) st = (vi > 1) ? C_PENAL : C_TIMEOUT;
                end
                C_REGISTRA: st = C_COMPARA;
                C_COMPARA: begin
                    if (!bus.igual) st = (vi > 1) ? C_PENAL : C_ERROU;
                    else if (en == ro) st = C_ULTIMA;
                    else st = C_PROX_JOG;
                end
                C_PROX_JOG: begin en = en + 1; wa = 0; st = C_ESPERA; end
                C_ULTIMA:   st = (ro + 1 == li) ? C_ACERTOU : C_PROX_ROD;
                C_PROX_ROD: begin ro = ro + 1; st = C_RODADA; end
                C_PENAL:    begin vi = vi - 1; st = C_RODADA; end
                default:    if (bus.iniciar) st = C_PREP;
            endcase
            m_st <= st; m_end <= en; m_rod <= ro; m_vid <= vi; m_wait <= wa; m_lim <= li;
            m_jd <= bus.jogada;
        end
    end

    always @(negedge clock) begin
        check("db_estado",  bus.db_estado,  m_st);
        check("endereco",   bus.endereco,   m_end);
        check("rodada",     bus.rodada,     m_rod);
        check("vidas",      bus.vidas,      m_vid);
        check("registraR",  bus.registraR,  m_st == C_REGISTRA);
        check("limpaR",     bus.limpaR,     m_st == C_INICIAL || m_st == C_PREP);
        check("penalidade", bus.penalidade, m_st == C_PENAL);
        check("pronto",     bus.pronto,     m_st == C_ERROU || m_st == C_ACERTOU || m_st == C_TIMEOUT);
        check("ganhou",     bus.ganhou,     m_st == C_ACERTOU);
        check("perdeu",     bus.perdeu,     m_st == C_ERROU || m_st == C_TIMEOUT);
        check("timeout",    bus.timeout,    m_st == C_TIMEOUT);
    end

    task automatic wait_state(input int code, input int budget, input string name);
        int n = 0;
        while (bus.db_estado !== 4'(code) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, bus.db_estado, code);
    endtask

    task automatic start_game(input logic m);
        bus.modo    = m;
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic restart(input logic m);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start_game(m);
    endtask

    task automatic jogar(input logic ok);
        wait_state(C_ESPERA, 100, "reach_espera");
        bus.jogada = 1'b1;
        bus.igual  = ok;
        @(negedge clock);
        bus.jogada = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, regs, pens, pen_at;
        reset = 1'b0;
        bus.iniciar = 1'b0; bus.modo = 1'b0; bus.jogada = 1'b0; bus.igual = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock); @(negedge clock);
        check("reset_estado", bus.db_estado, 0);
        check("reset_limpaR", bus.limpaR, 1);
        check("reset_vidas",  bus.vidas, 0);
        reset = 1'b0;

        // Async reset from state 3 in round 1, then a clean start sequence.
        start_game(1'b1);
        jogar(1'b1);
        wait_state(C_ESPERA, 50, "t1_espera");
        check("t1_rodada_before", bus.rodada, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_estado",   bus.db_estado, 0);
        check("t1_async_endereco", bus.endereco, 0);
        check("t1_async_rodada",   bus.rodada, 0);
        check("t1_async_vidas",    bus.vidas, 0);
        @(negedge clock);
        reset = 1'b0;
        start_game(1'b0);
        check("t1_seq_1", bus.db_estado, 1);
        @(negedge clock);
        check("t1_seq_2", bus.db_estado, 2);
        @(negedge clock);
        check("t1_seq_3", bus.db_estado, 3);
        check("t1_vidas", bus.vidas, 2);

        // Short game, all correct: 1 + 2 presses.
        restart(1'b0);
        repeat (3) jogar(1'b1);
        wait_state(C_ACERTOU, 50, "t2_final");
        check("t2_ganhou", bus.ganhou, 1);
        check("t2_pronto", bus.pronto, 1);
        check("t2_rodada", bus.rodada, 1);
        check("t2_vidas",  bus.vidas, 2);

        // Full game restarted straight from the final state: 1+2+3+4 presses.
        start_game(1'b1);
        repeat (10) jogar(1'b1);
        wait_state(C_ACERTOU, 50, "t3_final");
        check("t3_rodada",   bus.rodada, 3);
        check("t3_endereco", bus.endereco, 3);

        // Error in round 1 costs a life and replays the round; second error ends it.
        start_game(1'b1);
        jogar(1'b1);
        jogar(1'b1);
        jogar(1'b0);
        wait_state(C_PENAL, 10, "t4_penal");
        check("t4_pulse", bus.penalidade, 1);
        wait_state(C_ESPERA, 10, "t4_replay");
        check("t4_vidas",    bus.vidas, 1);
        check("t4_endereco", bus.endereco, 0);
        check("t4_rodada",   bus.rodada, 1);
        jogar(1'b0);
        wait_state(C_ERROU, 10, "t4_errou");
        check("t4_perdeu",  bus.perdeu, 1);
        check("t4_timeout", bus.timeout, 0);
        check("t4_vidas_f", bus.vidas, 1);

        // Last life: silent wait times out after exactly TO cycles.
        start_game(1'b0);
        jogar(1'b0);
        wait_state(C_ESPERA, 20, "t5_espera");
        n = 0;
        while (bus.db_estado === 4'(C_ESPERA) && n < 3 * TO) begin
            @(negedge clock);
            n++;
        end
        check("t5_cycles",  n, TO);
        check("t5_estado",  bus.db_estado, C_TIMEOUT);
        check("t5_timeout", bus.timeout, 1);
        check("t5_perdeu",  bus.perdeu, 1);

        // Edge in the last allowed cycle beats the timeout.
        start_game(1'b0);
        jogar(1'b0);
        wait_state(C_ESPERA, 20, "t5b_espera");
        repeat (TO - 1) @(negedge clock);
        bus.jogada = 1'b1;
        @(negedge clock);
        check("t5b_edge_wins", bus.db_estado, C_REGISTRA);
        bus.jogada = 1'b0;

        // Button held for 50 cycles: one registration, later visits time out.
        restart(1'b1);
        wait_state(C_ESPERA, 20, "t6_espera");
        bus.igual  = 1'b1;
        bus.jogada = 1'b1;
        regs = 0; pens = 0; pen_at = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            if (bus.registraR === 1'b1) regs++;
            if (bus.penalidade === 1'b1) begin
                pens++;
                if (pen_at == 0) pen_at = i;
            end
        end
        bus.jogada = 1'b0;
        check("t6_registraR_pulses", regs, 1);
        check("t6_penalidade_pulses", pens, 1);
        check("t6_penalidade_cycle", pen_at, 16);
        check("t6_final", bus.db_estado, C_TIMEOUT);

        // Random play, including mid-game resets and restarts.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.jogada = ~bus.jogada;
            bus.igual   = ($urandom_range(0, 7) != 0);
            bus.iniciar = ($urandom_range(0, 15) == 0);
            bus.modo    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
